// File: rtl/axi_llc_tag_req_arb.sv
// rtl/axi_llc_tag_req_arb.sv - tag store request arbiter with set lock table and config starvation guard
//
// Purpose: merges lookup descriptors and flush/BIST requests into one registered
// request stream for the tag store. A small lock table holds the indices of
// in-flight lookups so a new lookup never overtakes an operation on the same set.
// A starvation counter forces a pending config request through after MaxStarve
// lost arbitration cycles.
//
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   lookup_req_i/valid_i/ready_o     lookup descriptor handshake
//   cfg_req_i/valid_i/ready_o        flush / BIST request handshake
//   unlock_index_i, unlock_valid_i   retire pulse for a finished lookup
//   req_o/valid_o/ready_i            registered request to the tag store
//   locks_o                          number of occupied lock entries

package axi_llc_pkg;

  typedef struct packed {
    int unsigned SetAssociativity;
    int unsigned NumLines;
    int unsigned NumBlocks;
    int unsigned IndexLength;
  } llc_cfg_t;

  typedef enum logic [1:0] {
    Lookup = 2'd0,
    Flush  = 2'd1,
    Bist   = 2'd2
  } tag_mode_e;

  typedef struct packed {
    tag_mode_e   mode;
    logic [7:0]  indicator;
    logic [7:0]  index;
    logic [15:0] tag;
    logic        dirty;
  } tag_store_req_t;

endpackage

module axi_llc_tag_req_arb #(
  parameter axi_llc_pkg::llc_cfg_t Cfg         = axi_llc_pkg::llc_cfg_t'{default: '0},
  parameter type                   store_req_t = axi_llc_pkg::tag_store_req_t,
  parameter int unsigned           NumLocks    = 4,
  parameter int unsigned           MaxStarve   = 8,
  // An all-zero configuration would give a zero-width index; keep at least one bit.
  localparam int unsigned          IdxW        = (Cfg.IndexLength > 0) ? Cfg.IndexLength : 1,
  localparam int unsigned          LockCntW    = $clog2(NumLocks + 1),
  localparam int unsigned          StarveW     = $clog2(MaxStarve + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  store_req_t          lookup_req_i,
  input  logic                lookup_valid_i,
  output logic                lookup_ready_o,
  input  store_req_t          cfg_req_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [IdxW-1:0]     unlock_index_i,
  input  logic                unlock_valid_i,
  output store_req_t          req_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [LockCntW-1:0] locks_o
);

  logic [NumLocks-1:0]           lock_valid_q;
  logic [NumLocks-1:0][IdxW-1:0] lock_idx_q;
  logic [StarveW-1:0]            starve_q;

  logic [IdxW-1:0]     lookup_index;
  logic [NumLocks-1:0] unlock_match;
  logic [NumLocks-1:0] insert_oh;
  logic                free_found;
  logic                index_conflict;
  logic                out_load, force_cfg;
  logic                lookup_elig, cfg_elig;
  logic                lookup_hs, cfg_hs, unlock_hit;

  assign lookup_index = IdxW'(lookup_req_i.index);

  // Conflict check, unlock match and free-slot search all look at the table as
  // registered, so an entry freed this cycle only becomes usable next cycle.
  always_comb begin
    index_conflict = 1'b0;
    unlock_match   = '0;
    insert_oh      = '0;
    free_found     = 1'b0;
    for (int i = 0; i < NumLocks; i++) begin
      if (lock_valid_q[i] && (lock_idx_q[i] == lookup_index)) index_conflict = 1'b1;
      if (lock_valid_q[i] && (lock_idx_q[i] == unlock_index_i)) unlock_match[i] = 1'b1;
      if (!lock_valid_q[i] && !free_found) begin
        insert_oh[i] = 1'b1;
        free_found   = 1'b1;
      end
    end
  end

  assign out_load    = !valid_o || ready_i;
  assign force_cfg   = (starve_q == StarveW'(MaxStarve));
  assign lookup_elig = out_load && !(&lock_valid_q) && !index_conflict && !force_cfg;
  assign cfg_elig    = out_load && !(|lock_valid_q);

  assign lookup_ready_o = lookup_elig;
  assign cfg_ready_o    = cfg_elig && !(lookup_valid_i && lookup_elig);

  assign lookup_hs  = lookup_valid_i && lookup_ready_o;
  assign cfg_hs     = cfg_valid_i && cfg_ready_o;
  assign unlock_hit = unlock_valid_i && (|unlock_match);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_valid_q <= '0;
      lock_idx_q   <= '0;
      locks_o      <= '0;
      starve_q     <= '0;
      valid_o      <= 1'b0;
      req_o        <= '0;
    end else begin
      // The insert slot is free and the unlocked slot is valid, so they never collide.
      for (int i = 0; i < NumLocks; i++) begin
        if (lookup_hs && insert_oh[i]) begin
          lock_valid_q[i] <= 1'b1;
          lock_idx_q[i]   <= lookup_index;
        end else if (unlock_valid_i && unlock_match[i]) begin
          lock_valid_q[i] <= 1'b0;
        end
      end

      if (lookup_hs && !unlock_hit) begin
        locks_o <= locks_o + LockCntW'(1);
      end else if (!lookup_hs && unlock_hit) begin
        locks_o <= locks_o - LockCntW'(1);
      end

      if (!cfg_valid_i || cfg_hs) begin
        starve_q <= '0;
      end else if (!force_cfg) begin
        starve_q <= starve_q + StarveW'(1);
      end

      if (out_load) begin
        valid_o <= lookup_hs || cfg_hs;
        if (lookup_hs) begin
          req_o <= lookup_req_i;
        end else if (cfg_hs) begin
          req_o <= cfg_req_i;
        end
      end
    end
  end

  cfg_mode_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cfg_valid_i |-> (cfg_req_i.mode != axi_llc_pkg::Lookup));

  lookup_mode_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lookup_valid_i |-> (lookup_req_i.mode == axi_llc_pkg::Lookup));

  unlock_has_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
    unlock_valid_i |-> (|unlock_match));

endmodule

// File: tb/tb_axi_llc_tag_req_arb.sv
// tb/tb_axi_llc_tag_req_arb.sv - self-checking bench for axi_llc_tag_req_arb

module tb_axi_llc_tag_req_arb;
  import axi_llc_pkg::*;

  localparam llc_cfg_t TbCfg = '{SetAssociativity: 8, NumLines: 256, NumBlocks: 4, IndexLength: 8};
  localparam int NL = 4;
  localparam int MS = 8;

  typedef tag_store_req_t req_t;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  req_t       lookup_req_i, cfg_req_i, req_o;
  logic       lookup_valid_i, lookup_ready_o;
  logic       cfg_valid_i, cfg_ready_o;
  logic [7:0] unlock_index_i;
  logic       unlock_valid_i;
  logic       valid_o, ready_i;
  logic [2:0] locks_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  axi_llc_tag_req_arb #(
    .Cfg         (TbCfg),
    .store_req_t (req_t),
    .NumLocks    (NL),
    .MaxStarve   (MS)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .lookup_req_i   (lookup_req_i),
    .lookup_valid_i (lookup_valid_i),
    .lookup_ready_o (lookup_ready_o),
    .cfg_req_i      (cfg_req_i),
    .cfg_valid_i    (cfg_valid_i),
    .cfg_ready_o    (cfg_ready_o),
    .unlock_index_i (unlock_index_i),
    .unlock_valid_i (unlock_valid_i),
    .req_o          (req_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .locks_o        (locks_o)
  );

  function automatic req_t mk(tag_mode_e m, logic [7:0] idx);
    req_t r;
    r.mode      = m;
    r.indicator = 8'($urandom);
    r.index     = idx;
    r.tag       = 16'($urandom);
    r.dirty     = 1'($urandom);
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    lookup_valid_i = 1'b0;
    cfg_valid_i    = 1'b0;
    unlock_valid_i = 1'b0;
    lookup_req_i   = mk(Lookup, 8'h00);
    cfg_req_i      = mk(Flush, 8'h00);
    unlock_index_i = 8'h00;
    ready_i        = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk_i);
    rst_ni = 1'b0;
    cyc();
    cyc();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    #1 rst_ni = 1'b0;
    #2;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", valid_o); end
    checks++; if (req_o !== '0) begin errors++; $display("FAIL rst_req got %0h exp 0", req_o); end
    checks++; if (locks_o !== 3'd0) begin errors++; $display("FAIL rst_locks got %0d exp 0", locks_o); end
    checks++; if (lookup_ready_o !== 1'b1) begin errors++; $display("FAIL rst_lookup_ready got %0b exp 1", lookup_ready_o); end
    checks++; if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready got %0b exp 1", cfg_ready_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    lookup_valid_i = 1'b1;
    lookup_req_i   = mk(Lookup, 8'h01);
    #1;
    checks++; if (cfg_ready_o !== 1'b0) begin errors++; $display("FAIL rst_cfg_ready_lkv got %0b exp 0", cfg_ready_o); end
    checks++; if (lookup_ready_o !== 1'b1) begin errors++; $display("FAIL rst_lookup_ready_lkv got %0b exp 1", lookup_ready_o); end
  endtask

  task automatic test_pipelined();
    req_t r;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      lookup_req_i   = mk(Lookup, 8'(8'h10 + k));
      lookup_valid_i = 1'b1;
      r = lookup_req_i;
      #1;
      checks++; if (lookup_ready_o !== 1'b1) begin errors++; $display("FAIL pipe_ready%0d got %0b exp 1", k, lookup_ready_o); end
      cyc();
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL pipe_valid%0d got %0b exp 1", k, valid_o); end
      checks++; if (req_o !== r) begin errors++; $display("FAIL pipe_req%0d got %0h exp %0h", k, req_o, r); end
      checks++; if (locks_o !== 3'(k + 1)) begin errors++; $display("FAIL pipe_locks%0d got %0d exp %0d", k, locks_o, k + 1); end
    end
    lookup_valid_i = 1'b0;
    cyc();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL pipe_drain_valid got %0b exp 0", valid_o); end
  endtask

  task automatic test_conflict();
    req_t r2;
    do_reset();
    lookup_req_i   = mk(Lookup, 8'h20);
    lookup_valid_i = 1'b1;
    cyc();
    lookup_req_i = mk(Lookup, 8'h20);
    r2 = lookup_req_i;
    for (int c = 1; c < 5; c++) begin
      #1;
      checks++; if (lookup_ready_o !== 1'b0) begin errors++; $display("FAIL conflict_stall_c%0d got %0b exp 0", c, lookup_ready_o); end
      cyc();
    end
    unlock_valid_i = 1'b1;
    unlock_index_i = 8'h20;
    #1;
    checks++; if (lookup_ready_o !== 1'b0) begin errors++; $display("FAIL conflict_unlock_cycle got %0b exp 0", lookup_ready_o); end
    cyc();
    unlock_valid_i = 1'b0;
    #1;
    checks++; if (lookup_ready_o !== 1'b1) begin errors++; $display("FAIL conflict_after_unlock got %0b exp 1", lookup_ready_o); end
    checks++; if (locks_o !== 3'd0) begin errors++; $display("FAIL conflict_locks0 got %0d exp 0", locks_o); end
    cyc();
    lookup_valid_i = 1'b0;
    checks++; if (req_o !== r2) begin errors++; $display("FAIL conflict_req got %0h exp %0h", req_o, r2); end
    checks++; if (locks_o !== 3'd1) begin errors++; $display("FAIL conflict_locks1 got %0d exp 1", locks_o); end
  endtask

  task automatic test_table_full();
    req_t r5, r6;
    do_reset();
    lookup_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      lookup_req_i = mk(Lookup, 8'(8'h30 + k));
      cyc();
    end
    lookup_req_i = mk(Lookup, 8'h34);
    r5 = lookup_req_i;
    #1;
    checks++; if (lookup_ready_o !== 1'b0) begin errors++; $display("FAIL full_stall got %0b exp 0", lookup_ready_o); end
    checks++; if (locks_o !== 3'd4) begin errors++; $display("FAIL full_locks4 got %0d exp 4", locks_o); end
    cyc();
    unlock_valid_i = 1'b1;
    unlock_index_i = 8'h31;
    #1;
    checks++; if (lookup_ready_o !== 1'b0) begin errors++; $display("FAIL full_unlock_cycle got %0b exp 0", lookup_ready_o); end
    cyc();
    unlock_valid_i = 1'b0;
    #1;
    checks++; if (lookup_ready_o !== 1'b1) begin errors++; $display("FAIL full_next_ready got %0b exp 1", lookup_ready_o); end
    checks++; if (locks_o !== 3'd3) begin errors++; $display("FAIL full_locks3 got %0d exp 3", locks_o); end
    cyc();
    lookup_valid_i = 1'b0;
    checks++; if (req_o !== r5) begin errors++; $display("FAIL full_fifth_req got %0h exp %0h", req_o, r5); end
    checks++; if (locks_o !== 3'd4) begin errors++; $display("FAIL full_relocked got %0d exp 4", locks_o); end
    unlock_valid_i = 1'b1;
    unlock_index_i = 8'h32;
    cyc();
    unlock_index_i = 8'h33;
    lookup_valid_i = 1'b1;
    lookup_req_i   = mk(Lookup, 8'h36);
    r6 = lookup_req_i;
    #1;
    checks++; if (lookup_ready_o !== 1'b1) begin errors++; $display("FAIL same_cycle_ready got %0b exp 1", lookup_ready_o); end
    cyc();
    unlock_valid_i = 1'b0;
    lookup_valid_i = 1'b0;
    checks++; if (locks_o !== 3'd3) begin errors++; $display("FAIL same_cycle_locks got %0d exp 3", locks_o); end
    checks++; if (req_o !== r6) begin errors++; $display("FAIL same_cycle_req got %0h exp %0h", req_o, r6); end
  endtask

  task automatic test_starvation();
    req_t rc, rl;
    do_reset();
    cfg_valid_i    = 1'b1;
    cfg_req_i      = mk(Flush, 8'hAA);
    rc             = cfg_req_i;
    lookup_valid_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      lookup_req_i = mk(Lookup, 8'(8'h40 + ((k < 4) ? k : 4)));
      #1;
      checks++; if (lookup_ready_o !== (k < 4)) begin errors++; $display("FAIL starve_lk_ready%0d got %0b exp %0b", k, lookup_ready_o, k < 4); end
      checks++; if (cfg_ready_o !== 1'b0) begin errors++; $display("FAIL starve_cfg_lost%0d got %0b exp 0", k, cfg_ready_o); end
      cyc();
    end
    for (int u = 0; u < 4; u++) begin
      unlock_valid_i = 1'b1;
      unlock_index_i = 8'(8'h40 + u);
      #1;
      checks++; if (lookup_ready_o !== 1'b0) begin errors++; $display("FAIL starve_force_block%0d got %0b exp 0", u, lookup_ready_o); end
      checks++; if (cfg_ready_o !== 1'b0) begin errors++; $display("FAIL starve_cfg_wait%0d got %0b exp 0", u, cfg_ready_o); end
      cyc();
    end
    unlock_valid_i = 1'b0;
    rl = lookup_req_i;
    #1;
    checks++; if (cfg_ready_o !== 1'b1) begin errors++; $display("FAIL starve_cfg_win got %0b exp 1", cfg_ready_o); end
    checks++; if (lookup_ready_o !== 1'b0) begin errors++; $display("FAIL starve_lk_still_blocked got %0b exp 0", lookup_ready_o); end
    cyc();
    cfg_valid_i = 1'b0;
    checks++; if (valid_o !== 1'b1 || req_o !== rc) begin errors++; $display("FAIL starve_flush_out got %0b/%0h exp 1/%0h", valid_o, req_o, rc); end
    #1;
    checks++; if (lookup_ready_o !== 1'b1) begin errors++; $display("FAIL starve_cleared got %0b exp 1", lookup_ready_o); end
    cyc();
    lookup_valid_i = 1'b0;
    checks++; if (req_o !== rl) begin errors++; $display("FAIL starve_lk_resume got %0h exp %0h", req_o, rl); end
  endtask

  task automatic test_backpressure();
    req_t r, r2;
    do_reset();
    ready_i        = 1'b0;
    lookup_valid_i = 1'b1;
    lookup_req_i   = mk(Lookup, 8'h50);
    r = lookup_req_i;
    #1;
    checks++; if (lookup_ready_o !== 1'b1) begin errors++; $display("FAIL bp_first_ready got %0b exp 1", lookup_ready_o); end
    cyc();
    lookup_req_i = mk(Lookup, 8'h51);
    r2 = lookup_req_i;
    cfg_valid_i  = 1'b1;
    cfg_req_i    = mk(Bist, 8'h00);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (valid_o !== 1'b1 || req_o !== r) begin errors++; $display("FAIL bp_hold%0d got %0b/%0h exp 1/%0h", c, valid_o, req_o, r); end
      checks++; if (lookup_ready_o !== 1'b0 || cfg_ready_o !== 1'b0) begin errors++; $display("FAIL bp_readies%0d got %0b%0b exp 00", c, lookup_ready_o, cfg_ready_o); end
      cyc();
    end
    ready_i = 1'b1;
    #1;
    checks++; if (lookup_ready_o !== 1'b1 || cfg_ready_o !== 1'b0) begin errors++; $display("FAIL bp_release got %0b%0b exp 10", lookup_ready_o, cfg_ready_o); end
    cyc();
    lookup_valid_i = 1'b0;
    cfg_valid_i    = 1'b0;
    checks++; if (req_o !== r2) begin errors++; $display("FAIL bp_next_req got %0h exp %0h", req_o, r2); end
  endtask

  task automatic test_reset_mid();
    req_t r;
    do_reset();
    lookup_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lookup_req_i = mk(Lookup, 8'(8'h60 + k));
      cyc();
    end
    lookup_valid_i = 1'b0;
    ready_i        = 1'b0;
    checks++; if (locks_o !== 3'd3 || valid_o !== 1'b1) begin errors++; $display("FAIL midrst_pre got %0d/%0b exp 3/1", locks_o, valid_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b exp 0", valid_o); end
    checks++; if (locks_o !== 3'd0) begin errors++; $display("FAIL midrst_locks got %0d exp 0", locks_o); end
    checks++; if (req_o !== '0) begin errors++; $display("FAIL midrst_req got %0h exp 0", req_o); end
    @(negedge clk_i);
    rst_ni         = 1'b1;
    ready_i        = 1'b1;
    lookup_valid_i = 1'b1;
    lookup_req_i   = mk(Lookup, 8'h61);
    r = lookup_req_i;
    #1;
    checks++; if (lookup_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_relock_ready got %0b exp 1", lookup_ready_o); end
    cyc();
    lookup_valid_i = 1'b0;
    checks++; if (req_o !== r || locks_o !== 3'd1) begin errors++; $display("FAIL midrst_relock got %0h/%0d exp %0h/1", req_o, locks_o, r); end
  endtask

  // Reference model: the set of locked indices, the output register contents and
  // the number of consecutive cycles the pending config request has lost.
  task automatic test_random();
    int   held[$];
    logic m_valid;
    req_t m_req;
    int   m_starve;
    logic cfg_pend;
    logic load, found, e_lr, e_cr, lk_hs, cf_hs;
    int   pos;
    do_reset();
    m_valid  = 1'b0;
    m_req    = '0;
    m_starve = 0;
    cfg_pend = 1'b0;
    for (int n = 0; n < 600; n++) begin
      lookup_valid_i = ($urandom_range(0, 3) != 0);
      lookup_req_i   = mk(Lookup, 8'($urandom_range(0, 7)));
      if (!cfg_pend && $urandom_range(0, 3) == 0) begin
        cfg_pend  = 1'b1;
        cfg_req_i = mk(($urandom_range(0, 1) != 0) ? Flush : Bist, 8'($urandom));
      end
      cfg_valid_i = cfg_pend;
      ready_i     = ($urandom_range(0, 3) != 0);
      if (held.size() > 0 && $urandom_range(0, 2) == 0) begin
        unlock_valid_i = 1'b1;
        unlock_index_i = 8'(held[$urandom_range(0, held.size() - 1)]);
      end else begin
        unlock_valid_i = 1'b0;
      end

      load  = !m_valid || ready_i;
      found = 1'b0;
      foreach (held[i]) if (held[i] == int'(lookup_req_i.index)) found = 1'b1;
      e_lr = load && (held.size() < NL) && !found && (m_starve < MS);
      e_cr = load && (held.size() == 0) && !(lookup_valid_i && e_lr);
      #1;
      checks++; if (lookup_ready_o !== e_lr) begin errors++; $display("FAIL rnd_lk_ready n=%0d got %0b exp %0b", n, lookup_ready_o, e_lr); end
      checks++; if (cfg_ready_o !== e_cr) begin errors++; $display("FAIL rnd_cfg_ready n=%0d got %0b exp %0b", n, cfg_ready_o, e_cr); end

      lk_hs = lookup_valid_i && e_lr;
      cf_hs = cfg_valid_i && e_cr;
      if (unlock_valid_i) begin
        pos = -1;
        foreach (held[i]) if (held[i] == int'(unlock_index_i)) pos = i;
        if (pos >= 0) held.delete(pos);
      end
      if (lk_hs) held.push_back(int'(lookup_req_i.index));
      if (!cfg_valid_i || cf_hs) m_starve = 0;
      else if (m_starve < MS) m_starve++;
      if (cf_hs) cfg_pend = 1'b0;
      if (load) begin
        m_valid = lk_hs || cf_hs;
        if (lk_hs) m_req = lookup_req_i;
        else if (cf_hs) m_req = cfg_req_i;
      end

      cyc();
      checks++; if (valid_o !== m_valid) begin errors++; $display("FAIL rnd_valid n=%0d got %0b exp %0b", n, valid_o, m_valid); end
      if (m_valid) begin
        checks++; if (req_o !== m_req) begin errors++; $display("FAIL rnd_req n=%0d got %0h exp %0h", n, req_o, m_req); end
      end
      checks++; if (locks_o !== 3'(held.size())) begin errors++; $display("FAIL rnd_locks n=%0d got %0d exp %0d", n, locks_o, held.size()); end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks %0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pipelined();
    test_conflict();
    test_table_full();
    test_starvation();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
